// File: rtl/hyperram_pkg.sv
// Shared types and CA-word helpers for the HyperRAM transaction scheduler.
package hyperram_pkg;

    localparam int CA_W         = 48;
    localparam int CA_RW_BIT    = 47;
    localparam int CA_SPACE_BIT = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_UPPER_LSB = 16;
    localparam int CA_UPPER_W   = 20;
    localparam int CA_LOWER_W   = 3;
    localparam int CA_ADDR_W    = CA_UPPER_W + CA_LOWER_W;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_LOAD,
        SCHED_ISSUE,
        SCHED_WAIT,
        SCHED_DONE
    } sched_state_t;

    // Memory space, wrapped-burst type; the upper address sits above the reserved field.
    function automatic logic [CA_W-1:0] build_ca(input logic rw, input logic [CA_ADDR_W-1:0] addr);
        logic [CA_W-1:0] ca;
        ca                                = '0;
        ca[CA_RW_BIT]                     = rw;
        ca[CA_SPACE_BIT]                  = 1'b0;
        ca[CA_BURST_BIT]                  = 1'b0;
        ca[CA_UPPER_LSB +: CA_UPPER_W]    = addr[CA_LOWER_W +: CA_UPPER_W];
        ca[CA_LOWER_W-1:0]                = addr[CA_LOWER_W-1:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperram_req_fifo.sv
// Per-channel request queue: synchronous FIFO with show-ahead read data.
module hyperram_req_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk_50,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= bump(wrPtr);
            if (pop)  rdPtr <= bump(rdPtr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/hyperram_txn_scheduler.sv
// Multi-channel HyperRAM request scheduler: round-robin over per-channel queues,
// splits requests into driver bursts and reports per-request completion.
module hyperram_txn_scheduler
    import hyperram_pkg::*;
#(
    parameter int  NUM_CH    = 2,
    parameter int  ADDR_W    = 23,
    parameter int  LEN_W     = 11,
    parameter int  MAX_BURST = 128,
    parameter int  Q_DEPTH   = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_50,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    input  logic [NUM_CH-1:0]        req_rw,
    output logic                     drv_start,
    output logic [CA_W-1:0]          drv_ca,
    output logic [LEN_W-1:0]         drv_len,
    output logic                     drv_rw,
    output logic [CH_W-1:0]          drv_ch,
    input  logic                     drv_done,
    output logic                     cmp_valid,
    output logic [CH_W-1:0]          cmp_ch,
    output logic                     busy
);

    localparam int ENTRY_W = ADDR_W + LEN_W + 1;
    localparam int CNT_W   = $clog2(Q_DEPTH) + 1;

    sched_state_t      state;
    sched_state_t      stateNext;
    logic [NUM_CH-1:0] fifoPush;
    logic [NUM_CH-1:0] fifoPop;
    logic [NUM_CH-1:0] fifoFull;
    logic [NUM_CH-1:0] fifoEmpty;
    logic [ENTRY_W-1:0] fifoData  [NUM_CH];
    logic [CNT_W-1:0]   fifoCount [NUM_CH];

    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   curCh;
    logic [CH_W-1:0]   grantCh;
    logic              grantAny;
    logic [ADDR_W-1:0] curAddr;
    logic [LEN_W-1:0]  curRem;
    logic              curRw;

    logic [ENTRY_W-1:0] entry;
    logic [ADDR_W-1:0]  entryAddr;
    logic [LEN_W-1:0]   entryLen;
    logic               entryRw;
    logic [LEN_W-1:0]   chunk;
    logic [LEN_W-1:0]   remAfter;
    logic [ADDR_W-1:0]  addrAfter;
    logic [ADDR_W-1:0]  burstAddr;
    logic [LEN_W-1:0]   burstLen;
    logic               burstRw;

    function automatic logic [LEN_W-1:0] clampChunk(input logic [LEN_W-1:0] rem);
        return (rem > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : rem;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : gChannel
        assign fifoPush[c]  = req_valid[c] & ~fifoFull[c];
        assign fifoPop[c]   = (state == SCHED_LOAD) && (curCh == CH_W'(c));
        assign req_ready[c] = (fifoCount[c] != CNT_W'(Q_DEPTH));

        hyperram_req_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (Q_DEPTH)
        ) uFifo (
            .clk_50   (clk_50),
            .resetn   (resetn),
            .push     (fifoPush[c]),
            .pushData ({req_rw[c], req_len[c*LEN_W +: LEN_W], req_addr[c*ADDR_W +: ADDR_W]}),
            .pop      (fifoPop[c]),
            .popData  (fifoData[c]),
            .full     (fifoFull[c]),
            .empty    (fifoEmpty[c]),
            .count    (fifoCount[c])
        );
    end

    assign entry     = fifoData[curCh];
    assign entryAddr = entry[ADDR_W-1:0];
    assign entryLen  = entry[ADDR_W +: LEN_W] & ~LEN_W'(1);
    assign entryRw   = entry[ENTRY_W-1];

    assign chunk     = clampChunk(curRem);
    assign remAfter  = curRem - chunk;
    assign addrAfter = curAddr + ADDR_W'(chunk >> 1);

    // Walk downward so the nearest non-empty channel after rrPtr wins; rrPtr itself is last resort.
    always_comb begin
        int idx;
        idx      = 0;
        grantCh  = rrPtr;
        grantAny = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(rrPtr) + i) % NUM_CH;
            if (!fifoEmpty[CH_W'(idx)]) begin
                grantCh  = CH_W'(idx);
                grantAny = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        drv_start = 1'b0;
        cmp_valid = 1'b0;
        busy      = (state != SCHED_IDLE);
        case (state)
            SCHED_IDLE:  if (grantAny) stateNext = SCHED_LOAD;
            SCHED_LOAD:  stateNext = (entryLen == '0) ? SCHED_DONE : SCHED_ISSUE;
            SCHED_ISSUE: begin
                drv_start = 1'b1;
                stateNext = SCHED_WAIT;
            end
            SCHED_WAIT:  if (drv_done) stateNext = (remAfter == '0) ? SCHED_DONE : SCHED_ISSUE;
            SCHED_DONE: begin
                cmp_valid = 1'b1;
                stateNext = SCHED_IDLE;
            end
            default:     stateNext = SCHED_IDLE;
        endcase
    end

    assign cmp_ch = curCh;

    // Burst descriptor is captured on entry to ISSUE so it is valid together with drv_start.
    always_comb begin
        burstAddr = addrAfter;
        burstLen  = clampChunk(remAfter);
        burstRw   = curRw;
        if (state == SCHED_LOAD) begin
            burstAddr = entryAddr;
            burstLen  = clampChunk(entryLen);
            burstRw   = entryRw;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            state <= SCHED_IDLE;
            rrPtr <= CH_W'(NUM_CH - 1);
            curCh <= '0;
        end else begin
            state <= stateNext;
            if (state == SCHED_IDLE && grantAny) begin
                rrPtr <= grantCh;
                curCh <= grantCh;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            drv_ca  <= '0;
            drv_len <= '0;
            drv_rw  <= 1'b0;
            drv_ch  <= '0;
        end else if (stateNext == SCHED_ISSUE) begin
            drv_ca  <= build_ca(burstRw, CA_ADDR_W'(burstAddr));
            drv_len <= burstLen;
            drv_rw  <= burstRw;
            drv_ch  <= curCh;
        end
    end

    always_ff @(posedge clk_50) begin
        if (state == SCHED_LOAD) begin
            curAddr <= entryAddr;
            curRem  <= entryLen;
            curRw   <= entryRw;
        end else if (state == SCHED_WAIT && drv_done) begin
            curAddr <= addrAfter;
            curRem  <= remAfter;
        end
    end

endmodule

// File: tb/tb_hyperram_txn_scheduler.sv
// Scoreboard bench for hyperram_txn_scheduler with a small reactive driver model.
module tb_hyperram_txn_scheduler;

    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 23;
    localparam int LEN_W     = 11;
    localparam int MAX_BURST = 128;
    localparam int Q_DEPTH   = 4;
    localparam int CH_W      = 1;

    logic                     clk_50 = 1'b0;
    logic                     resetn;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*LEN_W-1:0]  req_len;
    logic [NUM_CH-1:0]        req_rw;
    logic                     drv_start;
    logic [47:0]              drv_ca;
    logic [LEN_W-1:0]         drv_len;
    logic                     drv_rw;
    logic [CH_W-1:0]          drv_ch;
    logic                     drv_done;
    logic                     cmp_valid;
    logic [CH_W-1:0]          cmp_ch;
    logic                     busy;

    always #10 clk_50 = ~clk_50;

    hyperram_txn_scheduler #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST),
        .Q_DEPTH   (Q_DEPTH)
    ) dut (
        .clk_50    (clk_50),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_rw    (req_rw),
        .drv_start (drv_start),
        .drv_ca    (drv_ca),
        .drv_len   (drv_len),
        .drv_rw    (drv_rw),
        .drv_ch    (drv_ch),
        .drv_done  (drv_done),
        .cmp_valid (cmp_valid),
        .cmp_ch    (cmp_ch),
        .busy      (busy)
    );

    typedef struct {
        logic [47:0]      ca;
        logic [LEN_W-1:0] len;
        logic             rw;
        int               ch;
    } burst_t;

    burst_t expBurst[$];
    int     expCmp[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    logic   holdDone = 1'b0;
    int     strayReq = 0;
    int     startSeen = 0;
    int     cmpSeen = 0;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] modelCa(input logic rw, input logic [ADDR_W-1:0] a);
        logic [47:0] ca;
        ca        = '0;
        ca[47]    = rw;
        ca[35:16] = 20'(a >> 3);
        ca[2:0]   = a[2:0];
        return ca;
    endfunction

    task automatic expectReq(input int ch, input logic [ADDR_W-1:0] addr, input int len, input logic rw);
        int               rem;
        int               chunk;
        logic [ADDR_W-1:0] a;
        burst_t           b;
        rem = len & ~1;
        a   = addr;
        while (rem > 0) begin
            chunk = (rem > MAX_BURST) ? MAX_BURST : rem;
            b.ca  = modelCa(rw, a);
            b.len = LEN_W'(chunk);
            b.rw  = rw;
            b.ch  = ch;
            expBurst.push_back(b);
            a   = a + ADDR_W'(chunk / 2);
            rem = rem - chunk;
        end
        expCmp.push_back(ch);
    endtask

    task automatic pushReq(input int ch, input logic [ADDR_W-1:0] addr, input int len, input logic rw);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk_50);
        req_addr[ch*ADDR_W +: ADDR_W] = addr;
        req_len[ch*LEN_W +: LEN_W]    = LEN_W'(len);
        req_rw[ch]                    = rw;
        req_valid[ch]                 = 1'b1;
        while (!req_ready[ch] && waitCnt < 200) begin
            @(negedge clk_50);
            waitCnt++;
        end
        if (!req_ready[ch]) checkVal("push_timeout", {63'd0, req_ready[ch]}, 64'd1);
        @(posedge clk_50);
        #1 req_valid[ch] = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expCmp.size() != 0 || busy) && n < 3000) begin
            @(negedge clk_50);
            n++;
        end
        checkVal("drain_cmp_left", 64'(expCmp.size()), 64'd0);
        checkVal("drain_burst_left", 64'(expBurst.size()), 64'd0);
    endtask

    // Driver model and output monitor: answers each burst with drv_done two cycles into WAIT.
    initial begin
        burst_t      b;
        int          e;
        int          pendCnt;
        int          strayAck;
        int          lastDoneCyc;
        logic        awaitLat;
        logic [47:0] heldCa;
        pendCnt     = -1;
        strayAck    = 0;
        lastDoneCyc = 0;
        awaitLat    = 1'b0;
        heldCa      = '0;
        drv_done    = 1'b0;
        forever begin
            @(negedge clk_50);
            drv_done = 1'b0;
            if (!resetn) begin
                pendCnt  = -1;
                awaitLat = 1'b0;
                strayAck = strayReq;
                continue;
            end
            if (strayReq != strayAck) begin
                strayAck++;
                drv_done = 1'b1;
            end else if (pendCnt == 0 && !holdDone) begin
                checkVal("ca_stable", drv_ca, heldCa);
                drv_done    = 1'b1;
                pendCnt     = -1;
                lastDoneCyc = cyc;
                awaitLat    = 1'b1;
            end else if (pendCnt > 0) begin
                pendCnt--;
            end
            if (drv_start) begin
                startSeen++;
                awaitLat = 1'b0;
                if (expBurst.size() == 0) begin
                    checkVal("burst_unexpected", {63'd0, drv_start}, 64'd0);
                end else begin
                    b = expBurst.pop_front();
                    checkVal("burst_ca", drv_ca, b.ca);
                    checkVal("burst_len", drv_len, b.len);
                    checkVal("burst_rw", drv_rw, b.rw);
                    checkVal("burst_ch", drv_ch, b.ch);
                end
                heldCa  = drv_ca;
                pendCnt = 2;
            end
            if (cmp_valid) begin
                cmpSeen++;
                if (expCmp.size() == 0) begin
                    checkVal("cmp_unexpected", {63'd0, cmp_valid}, 64'd0);
                end else begin
                    e = expCmp.pop_front();
                    checkVal("cmp_ch", cmp_ch, e);
                end
                if (awaitLat) begin
                    checkVal("cmp_latency", 64'(cyc - lastDoneCyc), 64'd1);
                    awaitLat = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s0;
        int c0;
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_rw    = '0;
        repeat (3) @(negedge clk_50);
        checkVal("rst_busy", {63'd0, busy}, 64'd0);
        checkVal("rst_start", {63'd0, drv_start}, 64'd0);
        checkVal("rst_cmp", {63'd0, cmp_valid}, 64'd0);
        checkVal("rst_ready", 64'(req_ready), 64'd3);
        checkVal("rst_ca", drv_ca, 64'd0);
        checkVal("rst_len", 64'(drv_len), 64'd0);
        resetn = 1'b1;

        // Single read: launch latency and CA layout.
        expectReq(0, 23'h000010, 64, 1'b1);
        pushReq(0, 23'h000010, 64, 1'b1);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_50);
            if (drv_start) begin
                lat = n;
                break;
            end
        end
        checkVal("start_latency", 64'(lat), 64'd3);
        checkVal("t1_ca_const", drv_ca, 64'h8000_0002_0000);
        waitDrain();

        // Multi-burst write wrapping past the top of the address space.
        s0 = startSeen;
        c0 = cmpSeen;
        expectReq(1, 23'h7FFFF0, 300, 1'b0);
        pushReq(1, 23'h7FFFF0, 300, 1'b0);
        waitDrain();
        checkVal("t2_bursts", 64'(startSeen - s0), 64'd3);
        checkVal("t2_cmps", 64'(cmpSeen - c0), 64'd1);

        // Round-robin alternation with both queues loaded.
        doReset();
        c0 = cmpSeen;
        for (int k = 0; k < 3; k++) begin
            expectReq(0, 23'(32'h100 + k * 8), 2, k[0]);
            expectReq(1, 23'(32'h200 + k * 8), 2, ~k[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50);
            checkVal("t3_ready", 64'(req_ready), 64'd3);
            req_addr[0 +: ADDR_W]      = 23'(32'h100 + k * 8);
            req_addr[ADDR_W +: ADDR_W] = 23'(32'h200 + k * 8);
            req_len                    = {LEN_W'(2), LEN_W'(2)};
            req_rw                     = {~k[0], k[0]};
            req_valid                  = 2'b11;
        end
        @(negedge clk_50);
        req_valid = 2'b00;
        waitDrain();
        checkVal("t3_cmps", 64'(cmpSeen - c0), 64'd6);

        // Back-pressure: fill ch0 while the driver stalls, hold an extra request.
        c0 = cmpSeen;
        holdDone = 1'b1;
        expectReq(0, 23'h000400, 2, 1'b0);
        pushReq(0, 23'h000400, 2, 1'b0);
        repeat (6) @(negedge clk_50);
        for (int k = 1; k <= Q_DEPTH; k++) begin
            expectReq(0, 23'(32'h400 + k * 16), 4, 1'b1);
            pushReq(0, 23'(32'h400 + k * 16), 4, 1'b1);
        end
        @(negedge clk_50);
        checkVal("t4_full", {63'd0, req_ready[0]}, 64'd0);
        checkVal("t4_other_ready", {63'd0, req_ready[1]}, 64'd1);
        expectReq(0, 23'h000480, 6, 1'b0);
        req_addr[0 +: ADDR_W] = 23'h000480;
        req_len[0 +: LEN_W]   = LEN_W'(6);
        req_rw[0]             = 1'b0;
        req_valid[0]          = 1'b1;
        repeat (4) @(negedge clk_50);
        checkVal("t4_held", {63'd0, req_ready[0]}, 64'd0);
        checkVal("t4_no_cmp", 64'(cmpSeen - c0), 64'd0);
        holdDone = 1'b0;
        lat = 0;
        while (!req_ready[0] && lat < 50) begin
            @(negedge clk_50);
            lat++;
        end
        checkVal("t4_ready_back", {63'd0, req_ready[0]}, 64'd1);
        @(posedge clk_50);
        #1 req_valid[0] = 1'b0;
        waitDrain();
        checkVal("t4_cmps", 64'(cmpSeen - c0), 64'd6);

        // Zero-length and odd-length-one requests complete without a burst.
        s0 = startSeen;
        expectReq(1, 23'h000500, 0, 1'b1);
        pushReq(1, 23'h000500, 0, 1'b1);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_50);
            if (cmp_valid) begin
                lat = n;
                break;
            end
        end
        checkVal("t5_len0_latency", 64'(lat), 64'd3);
        waitDrain();
        expectReq(0, 23'h000510, 1, 1'b0);
        pushReq(0, 23'h000510, 1, 1'b0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_50);
            if (cmp_valid) begin
                lat = n;
                break;
            end
        end
        checkVal("t5_len1_latency", 64'(lat), 64'd3);
        waitDrain();
        checkVal("t5_no_start", 64'(startSeen - s0), 64'd0);

        // Reset in the middle of a burst with more work queued.
        holdDone = 1'b1;
        expectReq(0, 23'h000600, 64, 1'b1);
        pushReq(0, 23'h000600, 64, 1'b1);
        pushReq(0, 23'h000610, 4, 1'b0);
        pushReq(1, 23'h000620, 4, 1'b0);
        repeat (4) @(negedge clk_50);
        checkVal("t6_busy_pre", {63'd0, busy}, 64'd1);
        c0 = cmpSeen;
        s0 = startSeen;
        @(negedge clk_50);
        resetn = 1'b0;
        @(negedge clk_50);
        checkVal("t6_busy", {63'd0, busy}, 64'd0);
        checkVal("t6_start", {63'd0, drv_start}, 64'd0);
        checkVal("t6_cmp", {63'd0, cmp_valid}, 64'd0);
        checkVal("t6_ready", 64'(req_ready), 64'd3);
        expCmp.delete();
        expBurst.delete();
        @(negedge clk_50);
        resetn   = 1'b1;
        holdDone = 1'b0;
        @(negedge clk_50);
        strayReq++;
        repeat (6) @(negedge clk_50);
        checkVal("t6_stray_busy", {63'd0, busy}, 64'd0);
        checkVal("t6_stray_cmp", 64'(cmpSeen - c0), 64'd0);
        checkVal("t6_stray_start", 64'(startSeen - s0), 64'd0);
        expectReq(1, 23'h000700, 4, 1'b1);
        pushReq(1, 23'h000700, 4, 1'b1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic doReset();
        @(negedge clk_50);
        resetn = 1'b0;
        repeat (2) @(negedge clk_50);
        resetn = 1'b1;
    endtask

endmodule
